// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: merges per-source stall requests into a
// per-stage hold vector, sequences exception flushes and keeps stall stats.
module pipe_hazard_ctrl #(
  parameter int unsigned           STAGES    = 6,
  parameter int unsigned           NREQ      = 3,
  parameter logic [8*NREQ-1:0]     DEPTHS    = 24'h030201,
  parameter int unsigned           PC_W      = 32,
  parameter int unsigned           DRAIN_CYC = 2,
  parameter int unsigned           CNT_W     = 32,
  parameter int unsigned           TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stall_req,
  input  logic              excp_valid,
  input  logic [PC_W-1:0]   excp_pc,
  input  logic              cnt_clr,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              stall_timeout
);

  localparam int unsigned WD_W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  // Watchdog trips on the stalled cycle that brings the count to TIMEOUT-1.
  localparam logic [WD_W-1:0] WD_TRIP = (TIMEOUT >= 2) ? WD_W'(TIMEOUT - 2) : '0;
  localparam logic [3:0] DRAIN_LOAD  = (DRAIN_CYC > 0) ? 4'(DRAIN_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state, next_state;
  logic                flush_d;
  logic [PC_W-1:0]     new_pc_d;
  logic [3:0]          drain_cnt, drain_d;
  logic [STAGES-1:0]   merged;
  logic [WD_W-1:0]     wd_cnt;
  logic                stalled;

  // OR together the depth masks of every active request source.
  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned d;
      d = 32'(DEPTHS[8*i +: 8]);
      if (d > STAGES - 1) d = STAGES - 1;
      if (stall_req[i]) begin
        for (int unsigned j = 0; j < STAGES; j++) begin
          if (j <= d) merged[j] = 1'b1;
        end
      end
    end
  end

  // Hold vector is live only in RUN and never during reset.
  always_comb begin
    stall = '0;
    if (!rst && state == RUN) stall = merged;
  end

  assign stalled = |stall;
  assign busy    = (state != RUN);

  // Flush sequencer next-state and register inputs.
  always_comb begin
    next_state = state;
    flush_d    = 1'b0;
    new_pc_d   = new_pc;
    drain_d    = drain_cnt;
    case (state)
      RUN: begin
        if (excp_valid) begin
          next_state = FLUSH;
          flush_d    = 1'b1;
          new_pc_d   = excp_pc;
        end
      end
      FLUSH: begin
        if (DRAIN_CYC > 0) begin
          next_state = DRAIN;
          drain_d    = DRAIN_LOAD;
        end else begin
          next_state = RUN;
        end
      end
      DRAIN: begin
        if (drain_cnt == 4'd0) next_state = RUN;
        else                   drain_d    = drain_cnt - 4'd1;
      end
      default: next_state = RUN;
    endcase
  end

  // Sequencer state, flush and redirect target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush     <= 1'b0;
      new_pc    <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= next_state;
      flush     <= flush_d;
      new_pc    <= new_pc_d;
      drain_cnt <= drain_d;
    end
  end

  // Saturating total-stall counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)                   stall_cnt <= '0;
    else if (stalled && stall_cnt != '1)  stall_cnt <= stall_cnt + CNT_W'(1);
  end

  // Consecutive-stall watchdog with a sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else if (stalled) begin
      if (wd_cnt != WD_MAX)   wd_cnt        <= wd_cnt + WD_W'(1);
      if (wd_cnt >= WD_TRIP)  stall_timeout <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (watchdog shortened to TIMEOUT=8).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  stall_req;
  logic        excp_valid;
  logic [31:0] excp_pc;
  logic        cnt_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
  logic [31:0] stall_cnt;
  logic        stall_timeout;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .excp_valid(excp_valid),
    .excp_pc(excp_pc), .cnt_clr(cnt_clr), .stall(stall), .flush(flush),
    .new_pc(new_pc), .busy(busy), .stall_cnt(stall_cnt),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall_req = 3'b111; excp_valid = 1'b0; excp_pc = '0; cnt_clr = 1'b0;
    tick(); tick();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cnt", stall_cnt, 32'h0);
    chk("rst_timeout", 32'(stall_timeout), 32'h0);
    rst = 1'b0;

    // combinational merge
    stall_req = 3'b001; #1 chk("merge_001", 32'(stall), 32'h03);
    stall_req = 3'b010; #1 chk("merge_010", 32'(stall), 32'h07);
    stall_req = 3'b100; #1 chk("merge_100", 32'(stall), 32'h0f);
    stall_req = 3'b111; #1 chk("merge_111", 32'(stall), 32'h0f);
    stall_req = 3'b011; #1 chk("merge_011", 32'(stall), 32'h07);
    stall_req = 3'b000; #1 chk("merge_000", 32'(stall), 32'h00);

    // exception flush and drain, with ignored second exceptions
    do_reset();
    stall_req = 3'b111; excp_valid = 1'b1; excp_pc = 32'h1000;
    #1 chk("excp_cycle_stall", 32'(stall), 32'h0f);
    tick();
    chk("flush_hi", 32'(flush), 32'h1);
    chk("flush_pc", new_pc, 32'h1000);
    chk("flush_busy", 32'(busy), 32'h1);
    chk("flush_stall", 32'(stall), 32'h0);
    excp_pc = 32'h2000;
    tick();
    chk("drain1_flush", 32'(flush), 32'h0);
    chk("drain1_busy", 32'(busy), 32'h1);
    chk("drain1_stall", 32'(stall), 32'h0);
    chk("drain1_pc", new_pc, 32'h1000);
    tick();
    chk("drain2_flush", 32'(flush), 32'h0);
    chk("drain2_busy", 32'(busy), 32'h1);
    chk("drain2_stall", 32'(stall), 32'h0);
    excp_valid = 1'b0;
    tick();
    chk("run_busy", 32'(busy), 32'h0);
    chk("run_stall", 32'(stall), 32'h0f);
    chk("run_flush", 32'(flush), 32'h0);
    chk("run_pc", new_pc, 32'h1000);
    stall_req = 3'b000;

    // stall statistics with clear
    do_reset();
    stall_req = 3'b001;
    repeat (10) tick();
    chk("cnt_10", stall_cnt, 32'd10);
    cnt_clr = 1'b1;
    tick();
    chk("cnt_clr", stall_cnt, 32'd0);
    cnt_clr = 1'b0;
    repeat (3) tick();
    chk("cnt_3", stall_cnt, 32'd3);
    stall_req = 3'b000;

    // watchdog: a gap in stalling restarts the count
    do_reset();
    stall_req = 3'b010; repeat (5) tick();
    stall_req = 3'b000; tick();
    stall_req = 3'b010; repeat (5) tick();
    chk("wd_gap", 32'(stall_timeout), 32'h0);
    stall_req = 3'b000;

    // watchdog trip boundary and stickiness
    do_reset();
    stall_req = 3'b010;
    repeat (6) tick();
    chk("wd_6", 32'(stall_timeout), 32'h0);
    tick();
    chk("wd_7", 32'(stall_timeout), 32'h1);
    stall_req = 3'b000;
    repeat (3) tick();
    chk("wd_sticky", 32'(stall_timeout), 32'h1);
    do_reset();
    chk("wd_rst", 32'(stall_timeout), 32'h0);

    // reset mid-flush
    excp_valid = 1'b1; excp_pc = 32'h4000;
    tick();
    excp_valid = 1'b0;
    chk("mf_flush", 32'(flush), 32'h1);
    rst = 1'b1;
    tick();
    chk("mf_rst_flush", 32'(flush), 32'h0);
    chk("mf_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // reset mid-drain
    stall_req = 3'b001; repeat (3) tick();
    chk("md_cnt", stall_cnt, 32'd3);
    stall_req = 3'b000; excp_valid = 1'b1; excp_pc = 32'h3000;
    tick();
    excp_valid = 1'b0;
    tick();
    chk("md_busy", 32'(busy), 32'h1);
    chk("md_flush", 32'(flush), 32'h0);
    rst = 1'b1; stall_req = 3'b100;
    tick();
    chk("md_rst_busy", 32'(busy), 32'h0);
    chk("md_rst_flush", 32'(flush), 32'h0);
    chk("md_rst_cnt", stall_cnt, 32'd0);
    chk("md_rst_pc", new_pc, 32'h0);
    chk("md_rst_stall", 32'(stall), 32'h0);
    rst = 1'b0;
    #1 chk("md_post_stall", 32'(stall), 32'h0f);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
